// File: rtl/uart_boot_loader.sv
// UART boot loader: parses a framed load packet from the byte receiver into
// instruction-memory word writes and holds the core in reset until it loads cleanly.
module uart_boot_loader #(
  parameter int         ADDR_W      = 14,
  parameter int         BASE_ADDR   = 0,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         TIMEOUT_CYC = 2_500_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              clr_rdy,
  input  logic              rearm,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [TMO_W-1:0]  tmo_q;
  logic [15:0]       cnt_q;
  logic [1:0]        idx_q;
  logic [23:0]       asm_q;
  logic [7:0]        csum_q;
  logic              take;
  logic              in_pkt;
  logic              expire;

  // clr_rdy gates take so the byte still flagged during the acknowledge cycle is not re-read.
  assign take   = rx_rdy & ~clr_rdy;
  assign in_pkt = state_q inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
  // A byte arriving on the expiry cycle wins, hence the ~take term.
  assign expire = in_pkt & ~take & (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

  // NOTE: every variable driven here gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (take && rx_data == SYNC_BYTE) state_d = S_LEN0;
      S_LEN0: if (take) state_d = S_LEN1;
      S_LEN1: if (take) state_d = ({rx_data, cnt_q[7:0]} == 16'd0) ? S_CSUM : S_DATA;
      S_DATA: if (take && idx_q == 2'd3 && cnt_q == 16'd1) state_d = S_CSUM;
      S_CSUM: if (take) state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
      S_DONE, S_ERR: if (rearm) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (expire) state_d = S_ERR;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_rdy   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= ADDR_W'(BASE_ADDR);
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b1;
      busy      <= 1'b0;
      load_done <= 1'b0;
      load_err  <= 1'b0;
      tmo_q     <= '0;
      cnt_q     <= 16'd0;
      idx_q     <= 2'd0;
      asm_q     <= 24'd0;
      csum_q    <= 8'd0;
    end else begin
      clr_rdy   <= take;
      mem_we    <= 1'b0;
      busy      <= state_d inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
      load_done <= (state_d == S_DONE);
      load_err  <= (state_d == S_ERR);
      cpu_hold  <= (state_d != S_DONE);

      // Address advances once the strobe cycle is over, wrapping naturally.
      if (mem_we) mem_addr <= mem_addr + ADDR_W'(1);
      if ((state_q == S_DONE || state_q == S_ERR) && rearm) mem_addr <= ADDR_W'(BASE_ADDR);

      if (take || !in_pkt) tmo_q <= '0;
      else                 tmo_q <= tmo_q + TMO_W'(1);

      if (take) begin
        case (state_q)
          S_IDLE: csum_q <= 8'd0;
          S_LEN0: begin
            cnt_q[7:0] <= rx_data;
            csum_q     <= csum_q ^ rx_data;
          end
          S_LEN1: begin
            cnt_q[15:8] <= rx_data;
            csum_q      <= csum_q ^ rx_data;
            idx_q       <= 2'd0;
          end
          S_DATA: begin
            csum_q <= csum_q ^ rx_data;
            idx_q  <= idx_q + 2'd1;
            case (idx_q)
              2'd0: asm_q[7:0]   <= rx_data;
              2'd1: asm_q[15:8]  <= rx_data;
              2'd2: asm_q[23:16] <= rx_data;
              default: begin
                mem_wdata <= {rx_data, asm_q};
                mem_we    <= 1'b1;
                cnt_q     <= cnt_q - 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: table of whole packets plus directed
// sequences for receiver hold, inter-byte timeout and mid-packet reset.
module tb_uart_boot_loader;

  localparam int         ADDR_W      = 2;   // small so two-word packets wrap
  localparam int         BASE_ADDR   = 3;
  localparam int         TIMEOUT_CYC = 100;
  localparam logic [1:0] EXP_A0      = 2'd3;
  localparam logic [1:0] EXP_A1      = 2'd0;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              rx_rdy = 1'b0;
  logic [7:0]        rx_data = 8'd0;
  logic              clr_rdy;
  logic              rearm = 1'b0;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold, busy, load_done, load_err;

  uart_boot_loader #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR), .SYNC_BYTE(8'hA5), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rdy(clr_rdy),
    .rearm(rearm), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Write and acknowledge monitor.
  logic [ADDR_W-1:0] wa_q[$];
  logic [31:0]       wd_q[$];
  int                clr_cnt = 0;
  int                dup_cnt = 0;
  logic              clr_prev = 1'b0;

  always @(negedge clk) begin
    if (mem_we) begin
      wa_q.push_back(mem_addr);
      wd_q.push_back(mem_wdata);
    end
    if (clr_rdy) clr_cnt++;
    if (clr_rdy && clr_prev) dup_cnt++;
    clr_prev = clr_rdy;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Receiver model: byte presented now, dropped one cycle after clr_rdy.
  task automatic send_now(input logic [7:0] b);
    rx_rdy  = 1'b1;
    rx_data = b;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rx_rdy = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    send_now(b);
  endtask

  task automatic send_pkt(input logic [127:0] pkt, input int len);
    for (int i = 0; i < len; i++) send_byte(pkt[8*(len-1-i) +: 8]);
  endtask

  task automatic pulse_rearm();
    @(negedge clk);
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
  endtask

  typedef struct {
    string        name;
    int           len;
    logic [127:0] pkt;
    int           nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
    logic         done;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int wbase, cbase;
    logic drop_next;

    // Data XOR of 11..88 is 0x88, so the good checksum is 02^00^88 = 0x8A; 0x02 is a mismatch.
    vecs[0] = '{"good_2w",      12, 128'hA5020011223344556677888A, 2, 32'h44332211, 32'h88776655, 1'b1};
    vecs[1] = '{"bad_csum",     12, 128'hA50200112233445566778802, 2, 32'h44332211, 32'h88776655, 1'b0};
    vecs[2] = '{"junk_zero_len", 7, 128'h00FF5AA5000002,           0, 32'h0,        32'h0,        1'b0};
    vecs[3] = '{"zero_len",      4, 128'hA5000000,                 0, 32'h0,        32'h0,        1'b1};
    vecs[4] = '{"one_word",      8, 128'hA50100DEADBEEF23,         1, 32'hEFBEADDE, 32'h0,        1'b1};
    vecs[5] = '{"sync_as_data",  8, 128'hA50100A5A5A5A501,         1, 32'hA5A5A5A5, 32'h0,        1'b1};

    repeat (3) @(negedge clk);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd1);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_done_err", 32'({load_done, load_err, mem_we, clr_rdy}), 32'd0);
    check("rst_addr",     32'(mem_addr), 32'(EXP_A0));
    check("rst_wdata",    mem_wdata,     32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      pulse_rearm();
      check({vecs[v].name, "_pre_hold"}, 32'({cpu_hold, load_done, load_err}), 32'b100);
      check({vecs[v].name, "_pre_addr"}, 32'(mem_addr), 32'(EXP_A0));
      wbase = wa_q.size();
      cbase = clr_cnt;
      send_pkt(vecs[v].pkt, vecs[v].len);
      repeat (3) @(negedge clk);
      check({vecs[v].name, "_nwr"},  32'(wa_q.size() - wbase), 32'(vecs[v].nwr));
      check({vecs[v].name, "_clr"},  32'(clr_cnt - cbase), 32'(vecs[v].len));
      check({vecs[v].name, "_done"}, 32'(load_done), 32'(vecs[v].done));
      check({vecs[v].name, "_err"},  32'(load_err), 32'(!vecs[v].done));
      check({vecs[v].name, "_hold"}, 32'(cpu_hold), 32'(!vecs[v].done));
      check({vecs[v].name, "_busy"}, 32'(busy), 32'd0);
      if (wa_q.size() - wbase >= 1 && vecs[v].nwr >= 1) begin
        check({vecs[v].name, "_a0"}, 32'(wa_q[wbase]), 32'(EXP_A0));
        check({vecs[v].name, "_d0"}, wd_q[wbase], vecs[v].w0);
      end
      if (wa_q.size() - wbase >= 2 && vecs[v].nwr >= 2) begin
        check({vecs[v].name, "_a1"}, 32'(wa_q[wbase+1]), 32'(EXP_A1));
        check({vecs[v].name, "_d1"}, wd_q[wbase+1], vecs[v].w1);
      end
    end

    // Sync byte held until the receiver clears it: a single acknowledge.
    pulse_rearm();
    wbase = wa_q.size();
    cbase = clr_cnt;
    drop_next = 1'b0;
    @(negedge clk);
    rx_rdy  = 1'b1;
    rx_data = 8'hA5;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (drop_next) rx_rdy = 1'b0;
      if (clr_rdy) drop_next = 1'b1;
    end
    check("hold_one_clr", 32'(clr_cnt - cbase), 32'd1);
    check("hold_busy",    32'(busy), 32'd1);

    // Continue as A5 01 00 11 22, then go silent.
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (98) @(negedge clk);
    check("tmo99_busy", 32'(busy), 32'd1);
    check("tmo99_err",  32'(load_err), 32'd0);
    send_now(8'h33);   // consumed on the expiry edge
    check("tmo_byte_wins", 32'({busy, load_err}), 32'b10);
    repeat (98) @(negedge clk);
    check("tmo2_99_err", 32'(load_err), 32'd0);
    @(negedge clk);
    check("tmo_err",  32'(load_err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_hold", 32'(cpu_hold), 32'd1);
    check("tmo_nwr",  32'(wa_q.size() - wbase), 32'd0);

    // Reset mid-DATA, after one word has been written.
    pulse_rearm();
    wbase = wa_q.size();
    send_pkt(128'hA50200112233445566, 9);
    check("mid_nwr",  32'(wa_q.size() - wbase), 32'd1);
    check("mid_addr", 32'(mem_addr), 32'(EXP_A1));
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_addr",  32'(mem_addr), 32'(EXP_A0));
    check("arst_wdata", mem_wdata, 32'd0);
    check("arst_flags", 32'({cpu_hold, busy, load_done, load_err, mem_we, clr_rdy}), 32'b100000);
    @(negedge clk);
    rst_n = 1'b1;
    wbase = wa_q.size();
    send_pkt(vecs[0].pkt, vecs[0].len);
    repeat (3) @(negedge clk);
    check("post_nwr",  32'(wa_q.size() - wbase), 32'd2);
    check("post_done", 32'({load_done, cpu_hold}), 32'b10);
    if (wa_q.size() - wbase >= 2) begin
      check("post_a0", 32'(wa_q[wbase]), 32'(EXP_A0));
      check("post_d0", wd_q[wbase], 32'h44332211);
      check("post_a1", 32'(wa_q[wbase+1]), 32'(EXP_A1));
      check("post_d1", wd_q[wbase+1], 32'h88776655);
    end

    check("no_double_clr", 32'(dup_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
